// File: rtl/pacote_mips16.sv
// Shared constants for the 16-bit multicycle MIPS core.
// Holds the opcodes, ALU codes, FSM state encodings and the control bundle.
package pacote_mips16;

    localparam logic [3:0] OP_R    = 4'b0000;
    localparam logic [3:0] OP_LW   = 4'b0001;
    localparam logic [3:0] OP_SW   = 4'b0010;
    localparam logic [3:0] OP_BEQ  = 4'b0011;
    localparam logic [3:0] OP_ADDI = 4'b0100;
    localparam logic [3:0] OP_J    = 4'b0101;

    localparam logic [2:0] ULA_AND = 3'b000;
    localparam logic [2:0] ULA_OR  = 3'b001;
    localparam logic [2:0] ULA_ADD = 3'b010;
    localparam logic [2:0] ULA_SUB = 3'b011;
    localparam logic [2:0] ULA_SLT = 3'b100;

    localparam logic [1:0] PC_ULA     = 2'b00;
    localparam logic [1:0] PC_ULA_OUT = 2'b01;
    localparam logic [1:0] PC_SALTO   = 2'b10;

    localparam logic [1:0] B_REG = 2'b00;
    localparam logic [1:0] B_UM  = 2'b01;
    localparam logic [1:0] B_IMM = 2'b10;

    typedef enum logic [3:0] {
        INICIO     = 4'd0,
        BUSCA      = 4'd1,
        DECODIFICA = 4'd2,
        EXEC_R     = 4'd3,
        FIM_R      = 4'd4,
        CALC_END   = 4'd5,
        LE_MEM     = 4'd6,
        ESCREVE_LW = 4'd7,
        ESCREVE_SW = 4'd8,
        DESVIO     = 4'd9,
        SALTO      = 4'd10,
        EXEC_I     = 4'd11,
        FIM_I      = 4'd12
    } estado_t;

    typedef struct packed {
        logic       pc_escreve;
        logic       pc_escreve_cond;
        logic [1:0] fonte_pc;
        logic       i_ou_d;
        logic       mem_le;
        logic       mem_escreve;
        logic       ir_escreve;
        logic       reg_escreve;
        logic       reg_dst;
        logic       mem_para_reg;
        logic       ula_fonte_a;
        logic [1:0] ula_fonte_b;
        logic [2:0] sinal_ula;
    } ctrl_t;

    function automatic logic opcode_valido(input logic [3:0] op);
        return op inside {OP_R, OP_LW, OP_SW, OP_BEQ, OP_ADDI, OP_J};
    endfunction

endpackage

// File: rtl/unidade_controle_multiciclo_controle_ula.sv
// ALU control: maps the R-type funct field to a sinal_ula code.
// Ports: funct in (3), sinal_ula out (3), ilegal out (1, funct 101..111).
module controle_ula
    import pacote_mips16::*;
(
    input  logic [2:0] funct,
    output logic [2:0] sinal_ula,
    output logic       ilegal
);

    always_comb begin
        sinal_ula = ULA_AND;
        ilegal    = 1'b0;
        case (funct)
            3'b000:  sinal_ula = ULA_AND;
            3'b001:  sinal_ula = ULA_OR;
            3'b010:  sinal_ula = ULA_ADD;
            3'b011:  sinal_ula = ULA_SUB;
            3'b100:  sinal_ula = ULA_SLT;
            default: ilegal    = 1'b1;
        endcase
    end

endmodule

// File: rtl/unidade_controle_multiciclo.sv
// Multicycle control FSM for the 16-bit MIPS datapath, with memory wait timeout.
// Ports: clk, rst_n, opcode, funct, zero, mem_pronto in; datapath enables, estado, sticky flags out.
module unidade_controle_multiciclo
    import pacote_mips16::*;
#(
    parameter int TIMEOUT_MEM  = 15,
    parameter int LARG_TIMEOUT = 4
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic [3:0] opcode,
    input  logic [2:0] funct,
    input  logic       zero,
    input  logic       mem_pronto,
    output logic       pc_escreve,
    output logic       pc_escreve_cond,
    output logic [1:0] fonte_pc,
    output logic       i_ou_d,
    output logic       mem_le,
    output logic       mem_escreve,
    output logic       ir_escreve,
    output logic       reg_escreve,
    output logic       reg_dst,
    output logic       mem_para_reg,
    output logic       ula_fonte_a,
    output logic [1:0] ula_fonte_b,
    output logic [2:0] sinal_ula,
    output logic [3:0] estado,
    output logic       instr_ilegal,
    output logic       erro_mem
);

    localparam bit TEMPO_ON = (TIMEOUT_MEM != 0);
    // The limit fires on the TIMEOUT_MEM-th waiting cycle, i.e. count = limit-1.
    localparam logic [LARG_TIMEOUT-1:0] LIMITE =
        LARG_TIMEOUT'(TEMPO_ON ? TIMEOUT_MEM - 1 : 0);

    estado_t                 estado_q;
    estado_t                 estado_d;
    logic [LARG_TIMEOUT-1:0] espera_q;
    logic [LARG_TIMEOUT-1:0] espera_d;
    logic                    ilegal_q;
    logic                    erro_q;
    logic                    em_espera;
    logic                    estouro;
    logic                    fn_ilegal;
    logic [2:0]              sinal_fn;
    ctrl_t                   c;

    // zero only steers the datapath's PC mux in DESVIO; the FSM ignores it.
    logic zero_unused;
    assign zero_unused = zero;

    controle_ula u_controle_ula (
        .funct     (funct),
        .sinal_ula (sinal_fn),
        .ilegal    (fn_ilegal)
    );

    assign em_espera = (estado_q == BUSCA) ||
                       (estado_q == LE_MEM) ||
                       (estado_q == ESCREVE_SW);

    // A ready arriving on the limit cycle wins over the timeout.
    assign estouro = TEMPO_ON && em_espera &&
                     !mem_pronto && (espera_q == LIMITE);

    // Any exit from a wait (ready or timeout) leaves the count at zero,
    // so every entry into a wait state starts from zero.
    assign espera_d = (TEMPO_ON && em_espera && !mem_pronto && !estouro)
                    ? espera_q + 1'b1 : '0;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            estado_q <= INICIO;
        end else begin
            estado_q <= estado_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            espera_q <= '0;
            ilegal_q <= 1'b0;
            erro_q   <= 1'b0;
        end else begin
            espera_q <= espera_d;
            if ((estado_q == DECODIFICA && !opcode_valido(opcode)) ||
                (estado_q == EXEC_R && fn_ilegal)) begin
                ilegal_q <= 1'b1;
            end
            if (estouro) begin
                erro_q <= 1'b1;
            end
        end
    end

    always_comb begin
        estado_d = INICIO;
        case (estado_q)
            INICIO: estado_d = BUSCA;
            BUSCA:  estado_d = mem_pronto ? DECODIFICA : BUSCA;
            DECODIFICA: begin
                unique case (1'b1)
                    opcode == OP_R:    estado_d = EXEC_R;
                    opcode == OP_LW,
                    opcode == OP_SW:   estado_d = CALC_END;
                    opcode == OP_BEQ:  estado_d = DESVIO;
                    opcode == OP_ADDI: estado_d = EXEC_I;
                    opcode == OP_J:    estado_d = SALTO;
                    default:           estado_d = BUSCA;
                endcase
            end
            EXEC_R:   estado_d = fn_ilegal ? BUSCA : FIM_R;
            FIM_R:    estado_d = BUSCA;
            CALC_END: estado_d = (opcode == OP_SW) ? ESCREVE_SW : LE_MEM;
            LE_MEM: begin
                if (mem_pronto)   estado_d = ESCREVE_LW;
                else if (estouro) estado_d = BUSCA;
                else              estado_d = LE_MEM;
            end
            ESCREVE_LW: estado_d = BUSCA;
            ESCREVE_SW: begin
                if (mem_pronto || estouro) estado_d = BUSCA;
                else                       estado_d = ESCREVE_SW;
            end
            DESVIO:  estado_d = BUSCA;
            SALTO:   estado_d = BUSCA;
            EXEC_I:  estado_d = FIM_I;
            FIM_I:   estado_d = BUSCA;
            default: estado_d = INICIO;
        endcase
    end

    always_comb begin
        c = '0;
        case (estado_q)
            BUSCA: begin
                c.mem_le      = 1'b1;
                c.ula_fonte_b = B_UM;
                c.sinal_ula   = ULA_ADD;
                if (mem_pronto) begin
                    c.ir_escreve = 1'b1;
                    c.pc_escreve = 1'b1;
                    c.fonte_pc   = PC_ULA;
                end
            end
            DECODIFICA: begin
                c.ula_fonte_b = B_IMM;
                c.sinal_ula   = ULA_ADD;
            end
            EXEC_R: begin
                c.ula_fonte_a = 1'b1;
                c.ula_fonte_b = B_REG;
                c.sinal_ula   = sinal_fn;
            end
            FIM_R: begin
                c.reg_escreve = 1'b1;
                c.reg_dst     = 1'b1;
            end
            CALC_END, EXEC_I: begin
                c.ula_fonte_a = 1'b1;
                c.ula_fonte_b = B_IMM;
                c.sinal_ula   = ULA_ADD;
            end
            LE_MEM: begin
                c.mem_le = 1'b1;
                c.i_ou_d = 1'b1;
            end
            ESCREVE_LW: begin
                c.reg_escreve  = 1'b1;
                c.mem_para_reg = 1'b1;
            end
            ESCREVE_SW: begin
                c.mem_escreve = 1'b1;
                c.i_ou_d      = 1'b1;
            end
            DESVIO: begin
                c.ula_fonte_a     = 1'b1;
                c.ula_fonte_b     = B_REG;
                c.sinal_ula       = ULA_SUB;
                c.pc_escreve_cond = 1'b1;
                c.fonte_pc        = PC_ULA_OUT;
            end
            SALTO: begin
                c.pc_escreve = 1'b1;
                c.fonte_pc   = PC_SALTO;
            end
            FIM_I: begin
                c.reg_escreve = 1'b1;
            end
            default: c = '0;
        endcase
    end

    assign pc_escreve      = c.pc_escreve;
    assign pc_escreve_cond = c.pc_escreve_cond;
    assign fonte_pc        = c.fonte_pc;
    assign i_ou_d          = c.i_ou_d;
    assign mem_le          = c.mem_le;
    assign mem_escreve     = c.mem_escreve;
    assign ir_escreve      = c.ir_escreve;
    assign reg_escreve     = c.reg_escreve;
    assign reg_dst         = c.reg_dst;
    assign mem_para_reg    = c.mem_para_reg;
    assign ula_fonte_a     = c.ula_fonte_a;
    assign ula_fonte_b     = c.ula_fonte_b;
    assign sinal_ula       = c.sinal_ula;
    assign estado          = estado_q;
    assign instr_ilegal    = ilegal_q;
    assign erro_mem        = erro_q;

endmodule

// File: tb/tb_unidade_controle_multiciclo.sv
// Bench for unidade_controle_multiciclo: per-instruction cycle model,
// per-cycle compare, plus literal latency and flag checks.
module tb_unidade_controle_multiciclo;

    localparam int T = 15;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic [3:0] opcode;
    logic [2:0] funct;
    logic       zero;
    logic       mem_pronto;
    logic       pc_escreve, pc_escreve_cond, i_ou_d, mem_le, mem_escreve;
    logic       ir_escreve, reg_escreve, reg_dst, mem_para_reg, ula_fonte_a;
    logic [1:0] fonte_pc, ula_fonte_b;
    logic [2:0] sinal_ula;
    logic [3:0] estado;
    logic       instr_ilegal, erro_mem;

    unidade_controle_multiciclo dut (
        .clk             (clk),
        .rst_n           (rst_n),
        .opcode          (opcode),
        .funct           (funct),
        .zero            (zero),
        .mem_pronto      (mem_pronto),
        .pc_escreve      (pc_escreve),
        .pc_escreve_cond (pc_escreve_cond),
        .fonte_pc        (fonte_pc),
        .i_ou_d          (i_ou_d),
        .mem_le          (mem_le),
        .mem_escreve     (mem_escreve),
        .ir_escreve      (ir_escreve),
        .reg_escreve     (reg_escreve),
        .reg_dst         (reg_dst),
        .mem_para_reg    (mem_para_reg),
        .ula_fonte_a     (ula_fonte_a),
        .ula_fonte_b     (ula_fonte_b),
        .sinal_ula       (sinal_ula),
        .estado          (estado),
        .instr_ilegal    (instr_ilegal),
        .erro_mem        (erro_mem)
    );

    always #5 clk = ~clk;

    typedef struct packed {
        logic       pc_w;
        logic       pc_wc;
        logic [1:0] fpc;
        logic       iod;
        logic       mle;
        logic       mw;
        logic       irw;
        logic       rw;
        logic       rdst;
        logic       m2r;
        logic       fa;
        logic [1:0] fb;
        logic [2:0] ula;
    } sai_t;

    typedef struct {
        logic [3:0] est;
        sai_t       s;
        logic       il;
        logic       em;
    } reg_t;

    reg_t       fila[$];
    int         vetores = 0;
    int         erros = 0;
    bit         il_m = 1'b0;
    bit         em_m = 1'b0;
    logic [3:0] op_cur = 4'd0;
    logic [2:0] fn_cur = 3'd0;
    int         ciclos = 0;
    int         lat;
    sai_t       dut_s;

    assign dut_s = {pc_escreve, pc_escreve_cond, fonte_pc, i_ou_d, mem_le,
                    mem_escreve, ir_escreve, reg_escreve, reg_dst,
                    mem_para_reg, ula_fonte_a, ula_fonte_b, sinal_ula};

    always @(negedge clk) begin
        reg_t e;
        if (fila.size() > 0) begin
            e = fila.pop_front();
            vetores++;
            if (estado !== e.est || dut_s !== e.s ||
                instr_ilegal !== e.il || erro_mem !== e.em) begin
                erros++;
                $display("FAIL ciclo t=%0t estado=%0d exp %0d sinais=%h exp %h ilegal=%b exp %b erro_mem=%b exp %b",
                         $time, estado, e.est, dut_s, e.s,
                         instr_ilegal, e.il, erro_mem, e.em);
            end
        end
    end

    task automatic chk(input string nome, input logic [31:0] got,
                       input logic [31:0] exp);
        vetores++;
        if (got !== exp) begin
            erros++;
            $display("FAIL %s got %0d expected %0d", nome, got, exp);
        end
    endtask

    function automatic sai_t alu(input bit fa, input logic [1:0] fb,
                                 input logic [2:0] u);
        sai_t v = '0;
        v.fa  = fa;
        v.fb  = fb;
        v.ula = u;
        return v;
    endfunction

    function automatic sai_t v_busca(input bit p);
        sai_t v = alu(1'b0, 2'b01, 3'b010);
        v.mle = 1'b1;
        v.irw = p;
        v.pc_w = p;
        return v;
    endfunction

    task automatic push_inicio();
        reg_t r;
        r.est = 4'd0;
        r.s   = '0;
        r.il  = il_m;
        r.em  = em_m;
        fila.push_back(r);
    endtask

    task automatic cyc(input logic [3:0] est, input bit p, input sai_t s);
        reg_t r;
        @(posedge clk);
        #1;
        opcode     = op_cur;
        funct      = fn_cur;
        mem_pronto = p;
        zero       = 1'($urandom_range(0, 1));
        r.est = est;
        r.s   = s;
        r.il  = il_m;
        r.em  = em_m;
        fila.push_back(r);
        ciclos++;
    endtask

    // Non-wait cycles get a random ready to show it is ignored there.
    task automatic passo(input logic [3:0] est, input sai_t s);
        cyc(est, 1'($urandom_range(0, 1)), s);
    endtask

    // n cycles of ready low, then ready high; the T-th consecutive
    // low cycle times out (fetch retries, data access gives up).
    task automatic espera(input logic [3:0] est, input int n,
                          input bit busca, output bit estourou);
        int   w = 0;
        bit   p;
        sai_t s;
        estourou = 1'b0;
        for (int k = 0; k < 1000; k++) begin
            p = (k >= n);
            if (busca) begin
                s = v_busca(p);
            end else begin
                s = '0;
                s.iod = 1'b1;
                if (est == 4'd6) s.mle = 1'b1;
                else             s.mw  = 1'b1;
            end
            cyc(est, p, s);
            if (p) break;
            if (w == T - 1) begin
                em_m = 1'b1;
                w = 0;
                estourou = 1'b1;
                if (!busca) break;
            end else begin
                w++;
            end
        end
    endtask

    task automatic run_instr(input logic [3:0] op, input logic [2:0] fn,
                             input int wf, input int wm, output int n);
        bit   to;
        sai_t s;
        op_cur = op;
        fn_cur = fn;
        ciclos = 0;
        espera(4'd1, wf, 1'b1, to);
        passo(4'd2, alu(1'b0, 2'b10, 3'b010));
        case (op)
            4'd0: begin
                if (fn > 3'd4) begin
                    passo(4'd3, alu(1'b1, 2'b00, 3'b000));
                    il_m = 1'b1;
                end else begin
                    passo(4'd3, alu(1'b1, 2'b00, fn));
                    s = '0;
                    s.rw = 1'b1;
                    s.rdst = 1'b1;
                    passo(4'd4, s);
                end
            end
            4'd1: begin
                passo(4'd5, alu(1'b1, 2'b10, 3'b010));
                espera(4'd6, wm, 1'b0, to);
                if (!to) begin
                    s = '0;
                    s.rw = 1'b1;
                    s.m2r = 1'b1;
                    passo(4'd7, s);
                end
            end
            4'd2: begin
                passo(4'd5, alu(1'b1, 2'b10, 3'b010));
                espera(4'd8, wm, 1'b0, to);
            end
            4'd3: begin
                s = alu(1'b1, 2'b00, 3'b011);
                s.pc_wc = 1'b1;
                s.fpc = 2'b01;
                passo(4'd9, s);
            end
            4'd4: begin
                passo(4'd11, alu(1'b1, 2'b10, 3'b010));
                s = '0;
                s.rw = 1'b1;
                passo(4'd12, s);
            end
            4'd5: begin
                s = '0;
                s.pc_w = 1'b1;
                s.fpc = 2'b10;
                passo(4'd10, s);
            end
            default: il_m = 1'b1;
        endcase
        n = ciclos;
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog: bench did not finish in time");
        $fatal(1);
    end

    initial begin
        sai_t s;
        opcode = 4'd0;
        funct = 3'd0;
        zero = 1'b0;
        mem_pronto = 1'b1;
        repeat (2) @(posedge clk);
        #1;
        chk("reset_estado", 32'(estado), 0);
        chk("reset_sinais", 32'(dut_s), 0);
        chk("reset_ilegal", 32'(instr_ilegal), 0);
        chk("reset_erro_mem", 32'(erro_mem), 0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        push_inicio();

        run_instr(4'd0, 3'b010, 0, 0, lat); chk("lat_r_add", lat, 4);
        run_instr(4'd0, 3'b000, 0, 0, lat); chk("lat_r_and", lat, 4);
        run_instr(4'd0, 3'b001, 0, 0, lat); chk("lat_r_or", lat, 4);
        run_instr(4'd0, 3'b011, 0, 0, lat); chk("lat_r_sub", lat, 4);
        run_instr(4'd0, 3'b100, 0, 0, lat); chk("lat_r_slt", lat, 4);
        run_instr(4'd1, 3'b000, 0, 3, lat); chk("lat_lw_w3", lat, 8);
        run_instr(4'd1, 3'b000, 0, 0, lat); chk("lat_lw", lat, 5);
        run_instr(4'd2, 3'b000, 0, 2, lat); chk("lat_sw_w2", lat, 6);
        run_instr(4'd2, 3'b000, 0, 0, lat); chk("lat_sw", lat, 4);
        run_instr(4'd4, 3'b000, 0, 0, lat); chk("lat_addi", lat, 4);
        run_instr(4'd3, 3'b000, 0, 0, lat); chk("lat_beq", lat, 3);
        run_instr(4'd5, 3'b000, 0, 0, lat); chk("lat_j", lat, 3);

        // ready on the 15th waiting fetch cycle completes without error
        run_instr(4'd4, 3'b000, 14, 0, lat); chk("lat_fetch_limite", lat, 18);
        chk("erro_mem_limite", 32'(erro_mem), 0);

        run_instr(4'hF, 3'b000, 0, 0, lat); chk("lat_op_ilegal", lat, 2);
        run_instr(4'd0, 3'b111, 0, 0, lat); chk("lat_fn_ilegal", lat, 3);
        chk("ilegal_sticky", 32'(instr_ilegal), 1);

        // fetch timeout after 15 waits, refetch succeeds after 5 more
        run_instr(4'd0, 3'b001, 20, 0, lat); chk("lat_timeout", lat, 24);
        chk("erro_mem_timeout", 32'(erro_mem), 1);

        // LW aborted by reset in the middle of LE_MEM
        op_cur = 4'd1;
        fn_cur = 3'd0;
        cyc(4'd1, 1'b1, v_busca(1'b1));
        passo(4'd2, alu(1'b0, 2'b10, 3'b010));
        passo(4'd5, alu(1'b1, 2'b10, 3'b010));
        s = '0;
        s.mle = 1'b1;
        s.iod = 1'b1;
        cyc(4'd6, 1'b0, s);
        cyc(4'd6, 1'b0, s);
        @(posedge clk);
        #3;
        rst_n = 1'b0;
        #1;
        chk("abort_estado", 32'(estado), 0);
        chk("abort_sinais", 32'(dut_s), 0);
        chk("abort_ilegal", 32'(instr_ilegal), 0);
        chk("abort_erro_mem", 32'(erro_mem), 0);
        il_m = 1'b0;
        em_m = 1'b0;
        push_inicio();
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        push_inicio();

        run_instr(4'd1, 3'b000, 0, 1, lat); chk("lat_lw_pos_reset", lat, 6);
        run_instr(4'd0, 3'b010, 0, 0, lat); chk("lat_r_final", lat, 4);

        @(negedge clk);
        #1;
        chk("fila_vazia", 32'(fila.size()), 0);
        $display("== %0d vectors applied, %0d miscompares ==", vetores, erros);
        $finish;
    end

endmodule
